onehot_pin_decoder: RTL

Receive-side counterpart to the one-hot pin driver. Takes 24 raw pins from a second iCEBreaker-bitsy, driven by the one-hot shift pattern, and synchronizes and debounces them. Decodes the single active pin into a binary index, flags illegal multi-hot patterns, and pulses a strobe whenever a new valid position is accepted. It sits between the board's P0..P23 input pins and the status logic (LED, counters), with top-level wiring Pi → PINS[i].

---
 rtl/onehot_pins_pkg.sv | 38 +++
 rtl/pin_synchronizer.sv | 24 ++
 rtl/onehot_pin_decoder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/onehot_pins_pkg.sv
// rtl/onehot_pins_pkg.sv - shared pin width, FSM encoding and pattern classifier helpers
package onehot_pins_pkg;

    localparam int WIDTH              = 24;
    localparam int IDXW               = $clog2(WIDTH);
    localparam int LOG2STABLE_DEFAULT = 16;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        EVAL   = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Saturating popcount: 0, 1, or 2 meaning "two or more".
    function automatic logic [1:0] pop_class(input logic [WIDTH-1:0] v);
        logic [1:0] c;
        c = 2'd0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i] && (c != 2'd2)) begin
                c = c + 2'd1;
            end
        end
        return c;
    endfunction

    // Lowest set bit wins; only meaningful when exactly one bit is set.
    function automatic logic [IDXW-1:0] prio_index(input logic [WIDTH-1:0] v);
        logic [IDXW-1:0] r;
        r = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = IDXW'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pin_synchronizer.sv
// rtl/pin_synchronizer.sv - WIDTH-bit two-flop synchronizer for asynchronous pin levels
module pin_synchronizer #(
    parameter int WIDTH = 24
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] sync1;

    // Two back-to-back flops give the first stage a full cycle to resolve metastability.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1  <= '0;
            synced <= '0;
        end else begin
            sync1  <= pins;
            synced <= sync1;
        end
    end

endmodule

// File: rtl/onehot_pin_decoder.sv
// rtl/onehot_pin_decoder.sv - debounced one-hot pin decoder with index, error flag and change strobe
module onehot_pin_decoder
    import onehot_pins_pkg::*;
#(
    parameter int LOG2STABLE = LOG2STABLE_DEFAULT
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [WIDTH-1:0] PINS,
    output logic [IDXW-1:0] IDX,
    output logic            IDX_VALID,
    output logic            STROBE,
    output logic            ERR,
    output logic [7:0]      CHANGES
);

    logic [WIDTH-1:0]      sync2;
    logic [WIDTH-1:0]      sync2_q;
    logic [WIDTH-1:0]      stable;
    logic [LOG2STABLE-1:0] stab_cnt;
    logic                  changed;
    logic                  cnt_full;
    logic                  drift;
    logic [1:0]            pc;
    logic [IDXW-1:0]       enc;
    state_t                state;
    state_t                state_nxt;

    pin_synchronizer #(
        .WIDTH (WIDTH)
    ) u_sync (
        .CLK    (CLK),
        .RST    (RST),
        .pins   (PINS),
        .synced (sync2)
    );

    assign changed  = (sync2 != sync2_q);
    assign cnt_full = &stab_cnt;
    assign drift    = (state == HOLD) && (sync2 != stable);
    assign pc       = pop_class(sync2);
    assign enc      = prio_index(sync2);

    // Previous-cycle copy of the synchronized pins for edge detection.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync2_q <= '0;
        end else begin
            sync2_q <= sync2;
        end
    end

    // Stability counter: restarts on any change or when HOLD abandons the accepted pattern.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stab_cnt <= '0;
        end else if (changed || drift) begin
            stab_cnt <= '0;
        end else if (!cnt_full) begin
            stab_cnt <= stab_cnt + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= SETTLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: settle for a full window, evaluate once, then hold until the pins move.
    always_comb begin
        state_nxt = state;
        case (state)
            SETTLE: if (cnt_full && !changed) state_nxt = EVAL;
            EVAL:   state_nxt = HOLD;
            HOLD:   if (sync2 != stable) state_nxt = SETTLE;
            default: state_nxt = SETTLE;
        endcase
    end

    // Classification and registered outputs; only the EVAL cycle updates them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stable    <= '0;
            IDX       <= '0;
            IDX_VALID <= 1'b0;
            STROBE    <= 1'b0;
            ERR       <= 1'b0;
            CHANGES   <= 8'd0;
        end else begin
            STROBE <= 1'b0;
            if (state == EVAL) begin
                stable <= sync2;
                case (pc)
                    2'd0: begin
                        IDX_VALID <= 1'b0;
                        ERR       <= 1'b0;
                    end
                    2'd1: begin
                        IDX       <= enc;
                        IDX_VALID <= 1'b1;
                        ERR       <= 1'b0;
                        // A fresh position is one that differs from the last valid one.
                        if (!IDX_VALID || (IDX != enc)) begin
                            STROBE  <= 1'b1;
                            CHANGES <= CHANGES + 8'd1;
                        end
                    end
                    default: begin
                        IDX_VALID <= 1'b0;
                        ERR       <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
